// File: rtl/ntt_frame_scheduler.sv
// Frame buffer and phase-aligned issue scheduler in front of a fixed-latency NTT pipeline.
// Optional statistics counters are built only when NTT_SCHED_STATS_EN is defined.
module ntt_frame_scheduler #(
    parameter int W            = 32,
    parameter int RADIX        = 16,
    parameter int PIPE_LATENCY = 40
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_last,
    output logic [W-1:0] dp_data,
    input  logic [W-1:0] dp_result,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         frame_err,
    output logic [15:0]  frames_in,
    output logic [15:0]  frames_out
);

    localparam int CW = $clog2(RADIX);
    localparam int PW = CW + 1;
    localparam logic [CW-1:0] IDX_LAST   = CW'(RADIX - 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(2 * RADIX - 1);

    typedef enum logic [1:0] {
        LOAD       = 2'd0,
        WAIT_PHASE = 2'd1,
        ISSUE      = 2'd2
    } state_t;

    state_t           state_r, state_nxt_s;
    logic [CW-1:0]    wr_cnt_r, wr_cnt_nxt_s;
    logic [CW-1:0]    rd_cnt_r, rd_cnt_nxt_s;
    logic [PW-1:0]    phase_r;
    logic [W-1:0]     buf_r [RADIX];
    logic [PIPE_LATENCY-1:0] vld_sr_r;
    logic [PIPE_LATENCY-1:0] last_sr_r;
    logic             accept_s;
    logic             err_set_s;

    assign in_ready  = (state_r == LOAD);
    assign accept_s  = in_valid && in_ready;
    assign out_valid = vld_sr_r[PIPE_LATENCY-1];
    assign out_last  = last_sr_r[PIPE_LATENCY-1];

    // Next-state, buffer index and framing-error decode.
    always_comb begin
        state_nxt_s  = state_r;
        wr_cnt_nxt_s = wr_cnt_r;
        rd_cnt_nxt_s = rd_cnt_r;
        err_set_s    = 1'b0;
        case (state_r)
            LOAD: begin
                if (accept_s) begin
                    if (in_last) begin
                        wr_cnt_nxt_s = '0;
                        if (wr_cnt_r == IDX_LAST) begin
                            state_nxt_s = WAIT_PHASE;
                        end else begin
                            err_set_s = 1'b1;
                        end
                    end else if (wr_cnt_r == IDX_LAST) begin
                        wr_cnt_nxt_s = '0;
                        err_set_s    = 1'b1;
                    end else begin
                        wr_cnt_nxt_s = wr_cnt_r + CW'(1);
                    end
                end else begin
                    wr_cnt_nxt_s = wr_cnt_r;
                end
            end
            WAIT_PHASE: begin
                // Leave on the last phase so the first sample lands on phase 0.
                if (phase_r == PHASE_LAST) begin
                    state_nxt_s  = ISSUE;
                    rd_cnt_nxt_s = '0;
                end else begin
                    state_nxt_s = WAIT_PHASE;
                end
            end
            ISSUE: begin
                if (rd_cnt_r == IDX_LAST) begin
                    state_nxt_s  = LOAD;
                    rd_cnt_nxt_s = '0;
                end else begin
                    rd_cnt_nxt_s = rd_cnt_r + CW'(1);
                end
            end
            default: begin
                state_nxt_s  = LOAD;
                wr_cnt_nxt_s = '0;
                rd_cnt_nxt_s = '0;
            end
        endcase
    end

    // State, indices, phase counter and sticky framing error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= LOAD;
            wr_cnt_r  <= '0;
            rd_cnt_r  <= '0;
            phase_r   <= '0;
            frame_err <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            wr_cnt_r <= wr_cnt_nxt_s;
            rd_cnt_r <= rd_cnt_nxt_s;
            phase_r  <= phase_r + PW'(1);
            if (err_set_s) begin
                frame_err <= 1'b1;
            end
        end
    end

    // Frame buffer write port; contents are only observed during ISSUE.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            buf_r[wr_cnt_r] <= in_data;
        end
    end

    // Valid/last delay line matching the NTT pipeline latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_sr_r  <= '0;
            last_sr_r <= '0;
        end else begin
            vld_sr_r[0]  <= (state_r == ISSUE);
            last_sr_r[0] <= (state_r == ISSUE) && (rd_cnt_r == IDX_LAST);
            for (int i = 1; i < PIPE_LATENCY; i++) begin
                vld_sr_r[i]  <= vld_sr_r[i-1];
                last_sr_r[i] <= last_sr_r[i-1];
            end
        end
    end

    // Sample mux into the pipeline.
    always_comb begin
        if (state_r == ISSUE) begin
            dp_data = buf_r[rd_cnt_r];
        end else begin
            dp_data = '0;
        end
    end

    // Result pass-through gated by the delayed valid.
    always_comb begin
        if (out_valid) begin
            out_data = dp_result;
        end else begin
            out_data = '0;
        end
    end

`ifdef NTT_SCHED_STATS_EN
    logic [15:0] frames_in_r;
    logic [15:0] frames_out_r;

    // Frame statistics, wrapping modulo 2^16.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frames_in_r  <= 16'd0;
            frames_out_r <= 16'd0;
        end else begin
            if ((state_r == WAIT_PHASE) && (phase_r == PHASE_LAST)) begin
                frames_in_r <= frames_in_r + 16'd1;
            end
            if (out_last) begin
                frames_out_r <= frames_out_r + 16'd1;
            end
        end
    end

    assign frames_in  = frames_in_r;
    assign frames_out = frames_out_r;
`else
    assign frames_in  = 16'd0;
    assign frames_out = 16'd0;
`endif

endmodule

// File: tb/tb_ntt_frame_scheduler.sv
// Self-checking bench for ntt_frame_scheduler: directed and randomized frames
// checked every cycle against a schedule-level reference model.
module tb_ntt_frame_scheduler;

    localparam int W     = 32;
    localparam int RADIX = 16;
    localparam int LAT   = 40;
    localparam int PER   = 2 * RADIX;
    localparam int N     = 16384;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [W-1:0] in_data = '0;
    logic        in_last = 1'b0;
    logic [W-1:0] dp_data;
    logic [W-1:0] dp_result = '0;
    logic        out_valid;
    logic [W-1:0] out_data;
    logic        out_last;
    logic        frame_err;
    logic [15:0] frames_in;
    logic [15:0] frames_out;

    always #5 clk = ~clk;

    ntt_frame_scheduler #(.W(W), .RADIX(RADIX), .PIPE_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .dp_data(dp_data), .dp_result(dp_result),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .frame_err(frame_err), .frames_in(frames_in), .frames_out(frames_out)
    );

    int errors = 0;
    int checks = 0;
    int cur = 0;

    // Reference model: expected per-cycle outputs on an absolute timeline.
    logic [31:0] exp_dp [N];
    logic        exp_ov [N];
    logic        exp_ol [N];
    int          busy_until;
    logic        exp_err;
    logic [31:0] fq [$];
    int          starts [$];

    function automatic void model_clear();
        for (int i = 0; i < N; i++) begin
            exp_dp[i] = 32'd0;
            exp_ov[i] = 1'b0;
            exp_ol[i] = 1'b0;
        end
        busy_until = -1;
        exp_err    = 1'b0;
        fq.delete();
        starts.delete();
        cur = 0;
    endfunction

    // A completed frame issues at the first phase-0 cycle after WAIT_PHASE has seen the last phase.
    function automatic void schedule(input int c);
        int n;
        n = c + 2;
        while ((n % PER) != 0) n++;
        for (int k = 0; k < RADIX; k++) begin
            if (n + LAT + k < N) begin
                exp_dp[n+k]       = fq[k];
                exp_ov[n+LAT+k]   = 1'b1;
            end
        end
        if (n + LAT + RADIX - 1 < N) exp_ol[n+LAT+RADIX-1] = 1'b1;
        busy_until = n + RADIX - 1;
        starts.push_back(n);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cur, obs, expv);
        end
    endtask

    task automatic cycle(input logic v, input logic [31:0] d, input logic l, output logic acc);
        logic exp_ir;
        int fi, fo;
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        dp_result = $urandom;
        #1;
        if (cur >= N - 1) begin
            errors++;
            $display("FAIL cycle_budget cyc=%0d observed=over expected=under %0d", cur, N);
            $fatal(1, "cycle budget exceeded");
        end
        exp_ir = (cur > busy_until);
        fi = 0;
        fo = 0;
        foreach (starts[i]) begin
            if (starts[i] <= cur) fi++;
            if (starts[i] + LAT + RADIX <= cur) fo++;
        end
`ifndef NTT_SCHED_STATS_EN
        fi = 0;
        fo = 0;
`endif
        chk("in_ready",   32'(in_ready),   32'(exp_ir));
        chk("dp_data",    dp_data,         exp_dp[cur]);
        chk("out_valid",  32'(out_valid),  32'(exp_ov[cur]));
        chk("out_last",   32'(out_last),   32'(exp_ol[cur]));
        chk("out_data",   out_data,        exp_ov[cur] ? dp_result : 32'd0);
        chk("frame_err",  32'(frame_err),  32'(exp_err));
        chk("frames_in",  32'(frames_in),  32'(fi % 65536));
        chk("frames_out", 32'(frames_out), 32'(fo % 65536));
        acc = v && exp_ir;
        if (acc) begin
            fq.push_back(d);
            if (l) begin
                if (fq.size() == RADIX) schedule(cur);
                else exp_err = 1'b1;
                fq.delete();
            end else if (fq.size() == RADIX) begin
                exp_err = 1'b1;
                fq.delete();
            end
        end
        @(posedge clk);
        cur++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        logic a;
        repeat (n) cycle(1'b0, $urandom, 1'b0, a);
    endtask

    task automatic send_frame(input int n, input int last_idx, input logic rand_gap,
                              input logic [31:0] base, input logic rnd_data);
        int k = 0;
        int budget = 0;
        logic acc, v;
        logic [31:0] d;
        while (k < n && budget < 3000) begin
            v = rand_gap ? 1'($urandom_range(0, 1)) : 1'b1;
            d = rnd_data ? $urandom : base + 32'(k);
            cycle(v, d, (k == last_idx), acc);
            if (acc) k++;
            budget++;
        end
        chk("send_progress", 32'(k), 32'(n));
    endtask

    task automatic do_reset(input int hold);
        rst = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        #1;
        chk("rst_dp_data",    dp_data,           32'd0);
        chk("rst_out_valid",  32'(out_valid),    32'd0);
        chk("rst_out_last",   32'(out_last),     32'd0);
        chk("rst_out_data",   out_data,          32'd0);
        chk("rst_frame_err",  32'(frame_err),    32'd0);
        chk("rst_frames_in",  32'(frames_in),    32'd0);
        chk("rst_frames_out", 32'(frames_out),   32'd0);
        repeat (hold) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    initial begin
        int len;
        @(negedge clk);
        do_reset(3);

        // Plain frame 1..16 issued from phase 0.
        send_frame(16, 15, 1'b0, 32'd1, 1'b0);
        idle(100);

        // Short frame flags an error, the following good frame still issues.
        send_frame(10, 9, 1'b0, 32'h100, 1'b0);
        send_frame(16, 15, 1'b0, 32'h200, 1'b0);
        idle(110);

        // Frame whose last sample lands on phase 5.
        while ((cur % PER) != 22) idle(1);
        send_frame(16, 15, 1'b0, 32'h300, 1'b0);
        idle(110);

        // Back-to-back frames with in_valid held high.
        send_frame(16, 15, 1'b0, 32'h400, 1'b0);
        send_frame(16, 15, 1'b0, 32'h500, 1'b0);
        idle(130);

        // Randomized frames with toggling valid, some malformed.
        for (int f = 0; f < 6; f++) begin
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : RADIX;
            send_frame(len, len - 1, 1'b1, 32'd0, 1'b1);
        end
        send_frame(RADIX, -1, 1'b1, 32'd0, 1'b1);
        send_frame(RADIX, RADIX - 1, 1'b1, 32'd0, 1'b1);
        idle(130);

        // Reset on the 8th issued sample discards everything in flight.
        send_frame(16, 15, 1'b0, 32'h600, 1'b0);
        while (cur < starts[starts.size()-1] + 7) idle(1);
        do_reset(2);
        idle(100);
        send_frame(16, 15, 1'b1, 32'd0, 1'b1);
        idle(110);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
